cnn_seq: RTL and testbench

CNN_SEQ -- requirements
Module: cnn_seq

---
 rtl/cnn_seq.sv | 150 +++++++++++++++
 tb/tb_cnn_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_seq.sv
`default_nettype none
// ============================================================================
// cnn_seq : inference sequencer stepping a layer controller through stages 1..6
// Revision : 1.0
// ============================================================================
module cnn_seq #(
    parameter int TIMEOUT = 1000000,
    parameter int CONFIRM = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        clear,
    input  logic        img_ready,
    input  logic [7:0]  return_ctrl,
    output logic [7:0]  ctrl,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_stage,
    output logic [31:0] run_cycles
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;
    localparam logic [2:0] c_LAST_STAGE = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_k, w_k_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [CW-1:0] r_conf, w_conf_nxt;
    logic [2:0]    r_err_stage, w_err_stage_nxt;
    logic [31:0]   r_run_cycles, w_run_cycles_nxt;
    logic [7:0]    r_ctrl, w_ctrl_nxt;

    logic w_match;
    logic w_legal;
    logic w_advance;
    logic w_timeout;

    // Stage 1 is only confirmed once the host has finished loading the image.
    assign w_match   = (return_ctrl == {5'd0, r_k}) && ((r_k != 3'd1) || img_ready);
    assign w_legal   = (return_ctrl == {5'd0, r_k}) || (return_ctrl == {5'd0, r_k - 3'd1});
    assign w_advance = w_match && (r_conf == CW'(CONFIRM - 1));
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_k          <= 3'd1;
            r_timer      <= '0;
            r_conf       <= '0;
            r_err_stage  <= 3'd0;
            r_run_cycles <= 32'd0;
            r_ctrl       <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_timer      <= w_timer_nxt;
            r_conf       <= w_conf_nxt;
            r_err_stage  <= w_err_stage_nxt;
            r_run_cycles <= w_run_cycles_nxt;
            r_ctrl       <= w_ctrl_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_k_nxt          = r_k;
        w_timer_nxt      = r_timer;
        w_conf_nxt       = r_conf;
        w_err_stage_nxt  = r_err_stage;
        w_run_cycles_nxt = r_run_cycles;
        w_ctrl_nxt       = r_ctrl;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt      = S_RUN;
                    w_k_nxt          = 3'd1;
                    w_timer_nxt      = '0;
                    w_conf_nxt       = '0;
                    w_err_stage_nxt  = 3'd0;
                    w_run_cycles_nxt = 32'd0;
                    w_ctrl_nxt       = 8'd1;
                end else if (clear && (r_state == S_DONE)) begin
                    w_state_nxt = S_IDLE;
                    w_ctrl_nxt  = 8'd0;
                end
            end

            S_RUN: begin
                if (r_run_cycles != 32'hFFFF_FFFF) begin
                    w_run_cycles_nxt = r_run_cycles + 32'd1;
                end
                if (abort) begin
                    w_state_nxt     = S_ERROR;
                    w_err_stage_nxt = r_k;
                    w_ctrl_nxt      = 8'd0;
                end else if (w_advance) begin
                    w_timer_nxt = '0;
                    w_conf_nxt  = '0;
                    // Leaving stage 6 keeps ctrl at 6 so the FC results stay valid.
                    if (r_k == c_LAST_STAGE) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt    = r_k + 3'd1;
                        w_ctrl_nxt = {5'd0, r_k + 3'd1};
                    end
                end else if (!w_legal || w_timeout) begin
                    w_state_nxt     = S_ERROR;
                    w_err_stage_nxt = r_k;
                    w_ctrl_nxt      = 8'd0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                    w_conf_nxt  = w_match ? (r_conf + CW'(1)) : '0;
                end
            end

            S_ERROR: begin
                if (clear) begin
                    w_state_nxt     = S_IDLE;
                    w_err_stage_nxt = 3'd0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_ctrl_nxt  = 8'd0;
            end
        endcase
    end

    assign ctrl       = r_ctrl;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERROR);
    assign err_stage  = r_err_stage;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cnn_seq.sv
`default_nettype none
// ============================================================================
// tb_cnn_seq : randomized and directed checks of cnn_seq against a stage model
// Revision : 1.0
// ============================================================================
module tb_cnn_seq;

    localparam int TIMEOUT = 64;
    localparam int CONFIRM = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        clear = 1'b0;
    logic        img_ready = 1'b1;
    logic [7:0]  return_ctrl = 8'd0;
    logic [7:0]  ctrl;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_stage;
    logic [31:0] run_cycles;

    cnn_seq #(.TIMEOUT(TIMEOUT), .CONFIRM(CONFIRM)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .clear       (clear),
        .img_ready   (img_ready),
        .return_ctrl (return_ctrl),
        .ctrl        (ctrl),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_stage   (err_stage),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: mode 0 idle, 1 running, 2 finished, 3 failed.
    int          m_mode;
    int          m_stage;
    int          m_age;
    int          m_streak;
    int          m_err;
    int          m_ctrl;
    logic [31:0] m_cyc;
    bit          mirror;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_stage = 1; m_age = 0; m_streak = 0; m_err = 0; m_cyc = 32'd0; m_ctrl = 0;
    endfunction

    function automatic void model_begin();
        m_mode = 1; m_stage = 1; m_age = 0; m_streak = 0; m_err = 0; m_cyc = 32'd0;
    endfunction

    function automatic void model_fail();
        m_mode = 3; m_err = m_stage;
    endfunction

    function automatic void model_step();
        int  rc;
        bit  ok;
        rc = int'(return_ctrl);
        case (m_mode)
            0: if (start) model_begin();
            1: begin
                if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
                ok = (rc == m_stage) && (m_stage != 1 || img_ready);
                if (abort) model_fail();
                else if (ok && (m_streak + 1 >= CONFIRM)) begin
                    if (m_stage == 6) m_mode = 2;
                    else begin
                        m_stage++; m_age = 0; m_streak = 0;
                    end
                end else if ((rc != m_stage && rc != m_stage - 1) || (m_age + 1 >= TIMEOUT)) model_fail();
                else begin
                    m_age++;
                    m_streak = ok ? m_streak + 1 : 0;
                end
            end
            2: begin
                if (start) model_begin();
                else if (clear) m_mode = 0;
            end
            default: if (clear) begin m_mode = 0; m_err = 0; end
        endcase
        m_ctrl = (m_mode == 1) ? m_stage : (m_mode == 2) ? 6 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("ctrl", ctrl, m_ctrl);
        check_val("busy", busy, m_mode == 1);
        check_val("done", done, m_mode == 2);
        check_val("error", error, m_mode == 3);
        check_val("err_stage", err_stage, m_err);
        check_val("run_cycles", run_cycles, m_cyc);
        if (mirror) return_ctrl = 8'(m_ctrl);
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        check_val("rst_ctrl", ctrl, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_error", error, 0);
        check_val("rst_err_stage", err_stage, 0);
        check_val("rst_run_cycles", run_cycles, 0);
        model_reset();
        start = 1'b0; abort = 1'b0; clear = 1'b0; return_ctrl = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_ctrl(input int v);
        int n;
        n = 0;
        mirror = 1'b1;
        return_ctrl = 8'(m_ctrl);
        while (ctrl != 8'(v) && n < 100) begin
            tick();
            n++;
        end
        check_val("reach_ctrl", ctrl, v);
    endtask

    task automatic finish_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clear_idle", {busy, done, error}, 3'b000);
    endtask

    initial begin
        int lat;
        int n;
        int r;
        mirror = 1'b1;
        model_reset();
        do_reset();

        // Nominal run with return_ctrl mirroring ctrl.
        img_ready = 1'b1;
        return_ctrl = 8'd0;
        pulse_start();
        check_val("nom_first_ctrl", ctrl, 1);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (!done) check_val("nom_ctrl_seq", ctrl, (lat / 2) + 1);
        end
        check_val("nom_latency", lat + 1, 13);
        check_val("nom_run_cycles", run_cycles, 12);
        check_val("nom_done_ctrl", ctrl, 6);

        // Restart from DONE with clear also asserted.
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check_val("done_restart_busy", busy, 1);
        check_val("done_restart_ctrl", ctrl, 1);

        // Slow conv2: previous stage status held for 50 cycles.
        run_to_ctrl(4);
        mirror = 1'b0;
        return_ctrl = 8'd3;
        repeat (50) tick();
        check_val("slow_hold_ctrl", ctrl, 4);
        check_val("slow_hold_busy", busy, 1);
        return_ctrl = 8'd4;
        n = 0;
        while (ctrl == 8'd4 && n < 10) begin
            tick();
            n++;
        end
        check_val("slow_adv_lat", n, 2);
        check_val("slow_adv_ctrl", ctrl, 5);
        run_to_ctrl(6);
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check_val("slow_done", done, 1);
        finish_clear();

        // Timeout while stuck at stage 2.
        pulse_start();
        run_to_ctrl(2);
        mirror = 1'b0;
        return_ctrl = 8'd1;
        n = 0;
        while (!error && n < 200) begin
            tick();
            n++;
        end
        check_val("tmo_cycles", n, TIMEOUT);
        check_val("tmo_err_stage", err_stage, 2);
        check_val("tmo_ctrl", ctrl, 0);
        finish_clear();
        check_val("tmo_clear_err_stage", err_stage, 0);

        // Start ignored in RUN, then illegal status at stage 3.
        pulse_start();
        run_to_ctrl(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_in_run_ctrl", ctrl, 3);
        mirror = 1'b0;
        return_ctrl = 8'h05;
        tick();
        check_val("viol_error", error, 1);
        check_val("viol_err_stage", err_stage, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_in_err", error, 1);
        finish_clear();

        // Abort coinciding with the final advance.
        pulse_start();
        run_to_ctrl(6);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_error", error, 1);
        check_val("abort_err_stage", err_stage, 6);
        check_val("abort_done", done, 0);
        finish_clear();

        // Asynchronous reset in the middle of stage 4.
        pulse_start();
        run_to_ctrl(4);
        do_reset();
        tick();
        check_val("post_rst_idle", busy, 0);

        // Randomized traffic.
        mirror = 1'b0;
        repeat (2500) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)      return_ctrl = 8'(m_ctrl);
            else if (r < 92) return_ctrl = 8'((m_ctrl > 0) ? m_ctrl - 1 : 0);
            else             return_ctrl = 8'($urandom_range(0, 7));
            start     = ($urandom_range(0, 99) < 6);
            abort     = ($urandom_range(0, 99) < 2);
            clear     = ($urandom_range(0, 99) < 6);
            img_ready = ($urandom_range(0, 99) < 85);
            tick();
        end
        start = 1'b0; abort = 1'b0; clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
